// File: rtl/hud_field_writer.sv
// Renders one BCD value into a configurable HUD field of the tile map, one glyph write per cycle, MSD first.
// Optional build macro LEADING_ZERO_BLANK_EN draws leading zeros with the blank tile instead of '0'.
module hud_field_writer #(
    parameter int NUM_FIELDS   = 3,
    parameter int MAX_DIGITS   = 8,
    parameter int MAP_COLS     = 40,
    parameter int ADDR_W       = 12,
    parameter int GLYPH_STRIDE = 16,
    parameter int DIGIT0_TILE  = 0,
    parameter int DASH_TILE    = 40,
    parameter int BLANK_TILE   = 36
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic [NUM_FIELDS*7-1:0]       fld_row,
    input  logic [NUM_FIELDS*7-1:0]       fld_col,
    input  logic [NUM_FIELDS*4-1:0]       fld_len,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [$clog2(NUM_FIELDS)-1:0] req_field,
    input  logic [MAX_DIGITS*4-1:0]       req_value,
    output logic                          wr_en,
    input  logic                          wr_ready,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [9:0]                    wr_data,
    output logic                          done
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int NIB_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [MAX_DIGITS*4-1:0] value_q, value_d;
    logic [NIB_W-1:0]        nib_q, nib_d;
    logic [CNT_W-1:0]        rem_q, rem_d;
`ifdef LEADING_ZERO_BLANK_EN
    logic                    lead_q, lead_d;
`endif

    logic [6:0]  sel_row, sel_col;
    logic [3:0]  sel_len;
    logic        field_ok;
    int unsigned len_i, avail_i, eff_i, base_i, tile_i;
    logic [3:0]  cur_nib;
    logic [9:0]  glyph;

    // Field lookup: an out-of-range index leaves everything zero, so it yields L=0.
    always_comb begin
        sel_row  = '0;
        sel_col  = '0;
        sel_len  = '0;
        field_ok = 1'b0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (32'(req_field) == i) begin
                sel_row  = fld_row[7*i +: 7];
                sel_col  = fld_col[7*i +: 7];
                sel_len  = fld_len[4*i +: 4];
                field_ok = 1'b1;
            end
        end
    end

    // Effective length clips to MAX_DIGITS and to the columns left on the row.
    always_comb begin
        len_i   = (32'(sel_len) > 32'(MAX_DIGITS)) ? 32'(MAX_DIGITS) : 32'(sel_len);
        avail_i = (32'(sel_col) >= 32'(MAP_COLS)) ? 32'd0 : 32'(MAP_COLS) - 32'(sel_col);
        eff_i   = (len_i < avail_i) ? len_i : avail_i;
        base_i  = 32'(sel_row) * 32'(MAP_COLS) + 32'(sel_col);
    end

    always_comb begin
        cur_nib = value_q[4*nib_q +: 4];
        tile_i  = (cur_nib < 4'd10) ? 32'(DIGIT0_TILE) + 32'(cur_nib) : 32'(DASH_TILE);
`ifdef LEADING_ZERO_BLANK_EN
        if (lead_q && cur_nib == 4'd0 && rem_q != CNT_W'(1)) begin
            tile_i = 32'(BLANK_TILE);
        end
`endif
        glyph = 10'(tile_i * 32'(GLYPH_STRIDE));
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            value_q <= '0;
            nib_q   <= '0;
            rem_q   <= '0;
`ifdef LEADING_ZERO_BLANK_EN
            lead_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            value_q <= value_d;
            nib_q   <= nib_d;
            rem_q   <= rem_d;
`ifdef LEADING_ZERO_BLANK_EN
            lead_q  <= lead_d;
`endif
        end
    end

    // NOTE: every variable gets a hold-value default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        value_d = value_q;
        nib_d   = nib_q;
        rem_d   = rem_q;
`ifdef LEADING_ZERO_BLANK_EN
        lead_d  = lead_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    value_d = req_value;
                    addr_d  = ADDR_W'(base_i);
                    nib_d   = NIB_W'(len_i - 32'd1);
                    rem_d   = CNT_W'(eff_i);
`ifdef LEADING_ZERO_BLANK_EN
                    lead_d  = 1'b1;
`endif
                    state_d = (field_ok && eff_i != 0) ? WRITE : DONE;
                end
            end
            WRITE: begin
                if (wr_ready) begin
                    addr_d = addr_q + ADDR_W'(1);
                    nib_d  = nib_q - NIB_W'(1);
                    rem_d  = rem_q - CNT_W'(1);
`ifdef LEADING_ZERO_BLANK_EN
                    if (cur_nib != 4'd0) lead_d = 1'b0;
`endif
                    if (rem_q == CNT_W'(1)) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE);
        wr_en     = (state_q == WRITE);
        wr_addr   = wr_en ? addr_q : '0;
        wr_data   = wr_en ? glyph : '0;
        done      = (state_q == DONE);
    end

endmodule

// File: doc/hud_field_writer.md
Name: hud_field_writer

Overview:
Parametrised successor to the fixed HUD layout constants. Renders N runtime-configurable numeric fields (score, lines, level, ...) into the tile-map RAM, one tile write per cycle. A single request carries a field index and a BCD value; the block sequences the glyph writes MSD-first with valid/ready flow control. It sits between game logic and the tile-map RAM write port.

Parameters:
NUM_FIELDS, 3, number of independently placed fields
MAX_DIGITS, 8, max digits per field (BCD nibbles in req_value)
MAP_COLS, 40, tile-map columns (row stride for address calc)
ADDR_W, 12, tile-map address width
GLYPH_STRIDE, 16, glyph-ROM start offset per tile index
DIGIT0_TILE, 0, tile index of glyph '0' ('1'..'9' follow contiguously)
DASH_TILE, 40, tile index written for invalid BCD nibble
BLANK_TILE, 36, tile index used for blanked leading zeros

Ports:
Clk  in  1  clock
Reset_n  in  1  asynchronous active-low reset
fld_row  in  NUM_FIELDS*7  per-field tile row, field i at [7i+6:7i]
fld_col  in  NUM_FIELDS*7  per-field left tile column
fld_len  in  NUM_FIELDS*4  per-field digit count, 0..MAX_DIGITS
req_valid  in  1  request present
req_ready  out  1  block idle, can accept
req_field  in  $clog2(NUM_FIELDS)  field index
req_value  in  MAX_DIGITS*4  BCD value, LSD in [3:0]
wr_en  out  1  tile write valid
wr_ready  in  1  RAM accepts write this cycle
wr_addr  out  ADDR_W  row*MAP_COLS + col
wr_data  out  10  glyph start offset = tile*GLYPH_STRIDE
done  out  1  one-cycle pulse, request complete

Behaviour:
- Reset: state IDLE; req_ready=1 once Reset_n high; wr_en=0, wr_addr=0, wr_data=0, done=0. Reset asserted mid-request aborts immediately; no further writes.
- States: IDLE, WRITE, DONE.
- IDLE: req_ready=1. Accept on req_valid&&req_ready; latch row, col, len of req_field and req_value. Out-of-range req_field: accept, emit no writes, go DONE.
- Effective length L = min(len, MAX_DIGITS, MAP_COLS-col) (column clipping; col>=MAP_COLS gives L=0). L=0 -> DONE next cycle.
- WRITE: first wr_en one cycle after acceptance. Digit k (k=L-1 down to 0, i.e. nibble [4k+3:4k]) written at column col+(L-1-k) when len not clipped; when clipped, the leftmost L digits of the len-digit field are written (nibbles len-1 .. len-L).
- wr_en/wr_addr/wr_data held stable while wr_ready=0; advance only on wr_en&&wr_ready. No idle cycles between writes when wr_ready stays high.
- Glyph: nibble 0-9 -> (DIGIT0_TILE+d)*GLYPH_STRIDE; nibble 10-15 -> DASH_TILE*GLYPH_STRIDE. Arithmetic truncated to 10 bits; address truncated to ADDR_W.
- After last write accepted: DONE for one cycle, done=1, wr_en=0, then IDLE. req_ready=0 in WRITE and DONE.
- Latency: L write cycles + 2 (accept->first write, DONE) with no backpressure.
- fld_* inputs sampled only at acceptance; changes during WRITE ignored.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: leading zero nibbles (from the most significant written digit downward, until the first non-zero nibble) write BLANK_TILE*GLYPH_STRIDE; the least significant written digit is always drawn as a digit. Invalid nibbles count as non-zero. Write count and timing unchanged.
- Not defined: all zeros drawn as '0'.

Test Plan:
- Field0 row 6 col 26 len 8, value 0x00012345, wr_ready=1 -> 8 consecutive writes addr 266..273, data 0,0,0,16,32,48,64,80; done pulses 10 cycles after acceptance.
- Same with LEADING_ZERO_BLANK_EN -> data 576,576,576,16,32,48,64,80; value 0 -> seven 576 then 0.
- wr_ready low 2 cycles during 3rd write -> addr 268/data 0 held stable, completion delayed exactly 2 cycles, no duplicate or skipped write.
- Field len 4 value 0x00A9 -> data 0,0,640,144 (dash for 0xA).
- Field row 3 col 38 len 4, value 0x1234 -> only 2 writes, addr 158,159, data 16,32; then done. len 0 -> no writes, done 2 cycles after acceptance.
- Reset_n low during 4th write -> wr_en=0 immediately; after release req_ready=1, next request completes normally.
